// File: rtl/fifo_stream_pkg.sv
// Shared constants and types for the FIFO pop-side streamer.
package fifo_stream_pkg;

  localparam int STREAM_BUF_DEPTH = 3;

  typedef logic [1:0] buf_idx_t;

  // Circular index advance; wraps after the last entry.
  function automatic buf_idx_t next_idx(input buf_idx_t idx);
    return (idx == buf_idx_t'(STREAM_BUF_DEPTH - 1)) ? '0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/fifo_pop_streamer_if.sv
// FIFO pop port and valid/ready output stream, bundled for the streamer.
interface fifo_pop_streamer_if #(
  parameter int DATA_W = 4
);
  logic              fifo_empty_i;
  logic              fifo_pop_o;
  logic [DATA_W-1:0] fifo_data_i;
  logic              m_valid_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_ready_i;

  modport master (
    input  fifo_empty_i, fifo_data_i, m_ready_i,
    output fifo_pop_o, m_valid_o, m_data_o
  );

  modport slave (
    output fifo_empty_i, fifo_data_i, m_ready_i,
    input  fifo_pop_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/stream_buf.sv
// Three-entry circular output buffer with push, pop, clear and head-data view.
module stream_buf
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output buf_idx_t          count_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic [DATA_W-1:0] mem_q [0:STREAM_BUF_DEPTH-1];
  logic [DATA_W-1:0] mem_d [0:STREAM_BUF_DEPTH-1];
  buf_idx_t          rd_idx_q, rd_idx_d;
  buf_idx_t          wr_idx_q, wr_idx_d;
  buf_idx_t          count_q, count_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    rd_idx_d = rd_idx_q;
    wr_idx_d = wr_idx_q;
    count_d  = count_q;
    if (clear) begin
      rd_idx_d = '0;
      wr_idx_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_idx_q] = push_data;
        wr_idx_d        = next_idx(wr_idx_q);
      end
      if (pop) begin
        rd_idx_d = next_idx(rd_idx_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the head is only observed while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_idx_q <= '0;
      wr_idx_q <= '0;
      count_q  <= '0;
    end else begin
      rd_idx_q <= rd_idx_d;
      wr_idx_q <= wr_idx_d;
      count_q  <= count_d;
    end
  end

  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_idx_q];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && !clear && count_q == buf_idx_t'(STREAM_BUF_DEPTH)));

  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(pop && !clear && count_q == '0));

endmodule

// File: rtl/fifo_pop_streamer.sv
// Pops a registered-read FIFO and re-presents the words as a valid/ready stream.
module fifo_pop_streamer
  import fifo_stream_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  fifo_pop_streamer_if.master bus,
  input  logic                flush_i,
  output logic                busy_o,
  output logic [CNT_W-1:0]    word_cnt_o
);

  logic              inflight_q, inflight_d;
  logic              discard_q, discard_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  buf_idx_t          buf_count;
  logic [DATA_W-1:0] head_data;
  logic [2:0]        credit_used;
  logic              pop_req;
  logic              capture;
  logic              m_valid;
  logic              handshake;

  // Credit covers buffered plus in-flight words, so a pop never waits on m_ready_i.
  always_comb begin
    credit_used = {1'b0, buf_count} + {2'b00, inflight_q};
    pop_req     = ~bus.fifo_empty_i & ~flush_i & ~reset
                & (credit_used <= 3'(STREAM_BUF_DEPTH - 1));
    m_valid     = (buf_count != '0);
    capture     = inflight_q & ~discard_q & ~flush_i;
    handshake   = m_valid & bus.m_ready_i & ~flush_i;
    inflight_d  = pop_req;
    discard_d   = flush_i & inflight_q;
    word_cnt_d  = word_cnt_q + CNT_W'(handshake);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  stream_buf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk         (clk),
    .reset       (reset),
    .clear       (flush_i),
    .push        (capture),
    .push_data   (bus.fifo_data_i),
    .pop         (handshake),
    .count_o     (buf_count),
    .head_data_o (head_data)
  );

  assign bus.fifo_pop_o = pop_req;
  assign bus.m_valid_o  = m_valid;
  assign bus.m_data_o   = m_valid ? head_data : '0;
  assign busy_o         = m_valid | inflight_q | ~bus.fifo_empty_i;
  assign word_cnt_o     = word_cnt_q;

endmodule
